// File: rtl/calc2_pkg.sv
// rtl/calc2_pkg.sv - calc2 command, response, completion and sequencer state types
package calc2_pkg;

    typedef enum logic [3:0] {
        reset_op = 4'h0,
        add_op   = 4'h1,
        sub_op   = 4'h2,
        shl_op   = 4'h5,
        shr_op   = 4'h6
    } operation_t;

    localparam operation_t NOP = reset_op;

    typedef enum logic [1:0] {
        RESP_NONE = 2'b00,
        RESP_OK   = 2'b01,
        RESP_ERR  = 2'b10,
        RESP_RSVD = 2'b11
    } resp_t;

    typedef struct packed {
        resp_t      resp;
        operation_t cmd;
    } cmp_rec_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OP1,
        ST_OP2
    } seq_state_t;

endpackage

// File: rtl/calc_tag_pool.sv
// rtl/calc_tag_pool.sv - per-port tag pool: busy mask, lowest-free allocator, cmd/age store, timeout
module calc_tag_pool
    import calc2_pkg::*;
#(
    parameter int TAG_W       = 2,
    parameter int TIMEOUT_CYC = 64,
    parameter int LAT_W       = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc,
    input  operation_t       alloc_cmd,
    input  logic             resp_valid,
    input  logic [TAG_W-1:0] rtag,
    output logic             any_free,
    output logic [TAG_W-1:0] alloc_tag,
    output logic             hit,
    output operation_t       hit_cmd,
    output logic [LAT_W-1:0] hit_age,
    output logic             timeout,
    output logic [TAG_W:0]   outstanding
);
    localparam int NTAG = 2 ** TAG_W;

    logic [NTAG-1:0]  busy;
    logic [NTAG-1:0]  expire;
    logic [NTAG-1:0]  free_mask;
    logic [NTAG-1:0]  alloc_mask;
    operation_t       cmd_store [NTAG];
    logic [LAT_W-1:0] age [NTAG];

    // Allocation looks only at the registered mask, so a tag freed this edge is not reused until the next.
    always_comb begin
        alloc_tag = '0;
        for (int i = NTAG - 1; i >= 0; i--) begin
            if (!busy[i]) alloc_tag = TAG_W'(i);
        end
    end

    assign any_free    = ~&busy;
    assign hit         = resp_valid && busy[rtag];
    assign hit_cmd     = cmd_store[rtag];
    assign hit_age     = age[rtag];
    assign timeout     = |expire;
    assign outstanding = (TAG_W + 1)'($countones(busy));

    // A tag expires as its age steps onto TIMEOUT_CYC; a response on that same edge takes precedence.
    always_comb begin
        expire     = '0;
        free_mask  = '0;
        alloc_mask = '0;
        for (int i = 0; i < NTAG; i++) begin
            expire[i]     = busy[i] && (age[i] == LAT_W'(TIMEOUT_CYC - 1)) && !(hit && rtag == TAG_W'(i));
            free_mask[i]  = expire[i] || (hit && rtag == TAG_W'(i));
            alloc_mask[i] = alloc && (alloc_tag == TAG_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
            for (int i = 0; i < NTAG; i++) begin
                age[i]       <= '0;
                cmd_store[i] <= NOP;
            end
        end else begin
            busy <= (busy & ~free_mask) | alloc_mask;
            for (int i = 0; i < NTAG; i++) begin
                if (alloc_mask[i]) begin
                    age[i]       <= '0;
                    cmd_store[i] <= alloc_cmd;
                end else if (busy[i] && !free_mask[i]) begin
                    age[i] <= age[i] + LAT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/calc_port_sequencer.sv
// rtl/calc_port_sequencer.sv - per-port calc2 request sequencer with tag tracking and completion reporting
module calc_port_sequencer
    import calc2_pkg::*;
#(
    parameter int NUM_PORTS   = 4,
    parameter int DATA_W      = 32,
    parameter int TAG_W       = 2,
    parameter int TIMEOUT_CYC = 64,
    localparam int LAT_W      = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic                  c_clk,
    input  logic                  reset,
    input  logic [NUM_PORTS-1:0]  req_valid,
    output logic [NUM_PORTS-1:0]  req_ready,
    input  operation_t            req_cmd      [NUM_PORTS],
    input  logic [DATA_W-1:0]     req_op1      [NUM_PORTS],
    input  logic [DATA_W-1:0]     req_op2      [NUM_PORTS],
    output operation_t            duv_cmd      [NUM_PORTS],
    output logic [DATA_W-1:0]     duv_data     [NUM_PORTS],
    output logic [TAG_W-1:0]      duv_tag      [NUM_PORTS],
    input  logic [1:0]            duv_resp     [NUM_PORTS],
    input  logic [TAG_W-1:0]      duv_rtag     [NUM_PORTS],
    input  logic [DATA_W-1:0]     duv_rdata    [NUM_PORTS],
    output logic [NUM_PORTS-1:0]  cmp_valid,
    output logic [TAG_W-1:0]      cmp_tag      [NUM_PORTS],
    output resp_t                 cmp_resp     [NUM_PORTS],
    output logic [DATA_W-1:0]     cmp_data     [NUM_PORTS],
    output operation_t            cmp_cmd      [NUM_PORTS],
    output logic [LAT_W-1:0]      cmp_lat      [NUM_PORTS],
    output logic [NUM_PORTS-1:0]  err_spurious,
    output logic [NUM_PORTS-1:0]  err_timeout,
    output logic [TAG_W:0]        outstanding  [NUM_PORTS]
);

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        seq_state_t       state, state_nxt;
        logic             ready, accept, resp_valid, any_free, hit, timeout;
        logic [TAG_W-1:0] alloc_tag, cur_tag, drv_tag, cmp_tag_q;
        operation_t       cur_cmd, hit_cmd, drv_cmd;
        logic [DATA_W-1:0] op1_q, op2_q, drv_data, cmp_data_q;
        logic [LAT_W-1:0] hit_age, cmp_lat_q;
        cmp_rec_t         rec_q;
        logic             cmp_valid_q, spur_q, timeout_q;

        assign resp_valid = (duv_resp[p] != 2'b00);
        assign ready      = ((state == ST_IDLE) || (state == ST_OP2)) && any_free;
        assign accept     = req_valid[p] && ready;

        calc_tag_pool #(
            .TAG_W       (TAG_W),
            .TIMEOUT_CYC (TIMEOUT_CYC),
            .LAT_W       (LAT_W)
        ) u_pool (
            .clk         (c_clk),
            .rst         (reset),
            .alloc       (accept),
            .alloc_cmd   (req_cmd[p]),
            .resp_valid  (resp_valid),
            .rtag        (duv_rtag[p]),
            .any_free    (any_free),
            .alloc_tag   (alloc_tag),
            .hit         (hit),
            .hit_cmd     (hit_cmd),
            .hit_age     (hit_age),
            .timeout     (timeout),
            .outstanding (outstanding[p])
        );

        always_comb begin
            state_nxt = state;
            drv_cmd   = NOP;
            drv_data  = '0;
            drv_tag   = '0;
            case (state)
                ST_IDLE: if (accept) state_nxt = ST_OP1;
                ST_OP1: begin
                    state_nxt = ST_OP2;
                    drv_cmd   = cur_cmd;
                    drv_data  = op1_q;
                    drv_tag   = cur_tag;
                end
                ST_OP2: begin
                    state_nxt = accept ? ST_OP1 : ST_IDLE;
                    drv_data  = op2_q;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end

        // All operands are captured at accept so the requester may move on immediately.
        always_ff @(posedge c_clk or posedge reset) begin
            if (reset) begin
                state       <= ST_IDLE;
                cur_cmd     <= NOP;
                cur_tag     <= '0;
                op1_q       <= '0;
                op2_q       <= '0;
                cmp_valid_q <= 1'b0;
                cmp_tag_q   <= '0;
                cmp_data_q  <= '0;
                cmp_lat_q   <= '0;
                rec_q       <= '{resp: RESP_NONE, cmd: NOP};
                spur_q      <= 1'b0;
                timeout_q   <= 1'b0;
            end else begin
                state       <= state_nxt;
                cmp_valid_q <= hit;
                spur_q      <= resp_valid && !hit;
                timeout_q   <= timeout;
                if (accept) begin
                    cur_cmd <= req_cmd[p];
                    cur_tag <= alloc_tag;
                    op1_q   <= req_op1[p];
                    op2_q   <= req_op2[p];
                end
                if (hit) begin
                    cmp_tag_q  <= duv_rtag[p];
                    cmp_data_q <= duv_rdata[p];
                    cmp_lat_q  <= hit_age;
                    rec_q      <= '{resp: resp_t'(duv_resp[p]), cmd: hit_cmd};
                end
            end
        end

        assign req_ready[p]    = ready;
        assign duv_cmd[p]      = drv_cmd;
        assign duv_data[p]     = drv_data;
        assign duv_tag[p]      = drv_tag;
        assign cmp_valid[p]    = cmp_valid_q;
        assign cmp_tag[p]      = cmp_tag_q;
        assign cmp_resp[p]     = rec_q.resp;
        assign cmp_data[p]     = cmp_data_q;
        assign cmp_cmd[p]      = rec_q.cmd;
        assign cmp_lat[p]      = cmp_lat_q;
        assign err_spurious[p] = spur_q;
        assign err_timeout[p]  = timeout_q;
    end

endmodule

// File: tb/tb_calc_port_sequencer.sv
// tb/tb_calc_port_sequencer.sv - self-checking bench for calc_port_sequencer
module tb_calc_port_sequencer;
    import calc2_pkg::*;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int TW = 2;
    localparam int TO = 16;
    localparam int LW = $clog2(TO + 1);
    localparam int NT = 4;

    logic c_clk = 1'b0;
    logic reset = 1'b1;
    always #5 c_clk = ~c_clk;

    logic [NP-1:0] req_valid, req_ready, cmp_valid, err_spurious, err_timeout;
    operation_t    req_cmd [NP], duv_cmd [NP], cmp_cmd [NP];
    logic [DW-1:0] req_op1 [NP], req_op2 [NP], duv_data [NP], duv_rdata [NP], cmp_data [NP];
    logic [TW-1:0] duv_tag [NP], duv_rtag [NP], cmp_tag [NP];
    logic [1:0]    duv_resp [NP];
    resp_t         cmp_resp [NP];
    logic [LW-1:0] cmp_lat [NP];
    logic [TW:0]   outstanding [NP];

    calc_port_sequencer #(.NUM_PORTS(NP), .DATA_W(DW), .TAG_W(TW), .TIMEOUT_CYC(TO)) dut (
        .c_clk(c_clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_op1(req_op1), .req_op2(req_op2),
        .duv_cmd(duv_cmd), .duv_data(duv_data), .duv_tag(duv_tag),
        .duv_resp(duv_resp), .duv_rtag(duv_rtag), .duv_rdata(duv_rdata),
        .cmp_valid(cmp_valid), .cmp_tag(cmp_tag), .cmp_resp(cmp_resp),
        .cmp_data(cmp_data), .cmp_cmd(cmp_cmd), .cmp_lat(cmp_lat),
        .err_spurious(err_spurious), .err_timeout(err_timeout), .outstanding(outstanding)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: tag table keyed by absolute cycle of issue; cycle numbers drive everything.
    int            cyc = 0;
    bit            m_busy [NP][NT];
    int            m_born [NP][NT];
    operation_t    m_tcmd [NP][NT];
    int            m_acc  [NP];
    operation_t    m_icmd [NP];
    logic [DW-1:0] m_op1 [NP], m_op2 [NP];
    int            m_itag [NP];
    bit            e_cv [NP], e_sp [NP], e_to [NP];
    int            e_tag [NP], e_lat [NP];
    logic [1:0]    e_resp [NP];
    logic [DW-1:0] e_data [NP];
    operation_t    e_cmd [NP];
    operation_t    ops [4] = '{add_op, sub_op, shl_op, shr_op};

    function automatic int n_busy(input int p);
        int n = 0;
        for (int t = 0; t < NT; t++) n += int'(m_busy[p][t]);
        return n;
    endfunction

    function automatic bit m_ready(input int p);
        return (cyc != m_acc[p]) && (n_busy(p) < NT);
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            m_acc[p] = -100;
            e_cv[p] = 0; e_sp[p] = 0; e_to[p] = 0;
            for (int t = 0; t < NT; t++) m_busy[p][t] = 0;
        end
    endtask

    task automatic check_outputs();
        operation_t    xc;
        logic [DW-1:0] xd;
        int            xt;
        for (int p = 0; p < NP; p++) begin
            xc = NOP; xd = '0; xt = 0;
            if (cyc == m_acc[p]) begin
                xc = m_icmd[p]; xd = m_op1[p]; xt = m_itag[p];
            end else if (cyc == m_acc[p] + 1) begin
                xd = m_op2[p];
            end
            check($sformatf("p%0d_ready", p), 64'(req_ready[p]), 64'(m_ready(p)));
            check($sformatf("p%0d_duv_cmd", p), 64'(duv_cmd[p]), 64'(xc));
            check($sformatf("p%0d_duv_data", p), 64'(duv_data[p]), 64'(xd));
            check($sformatf("p%0d_duv_tag", p), 64'(duv_tag[p]), 64'(xt));
            check($sformatf("p%0d_outstanding", p), 64'(outstanding[p]), 64'(n_busy(p)));
            check($sformatf("p%0d_cmp_valid", p), 64'(cmp_valid[p]), 64'(e_cv[p]));
            check($sformatf("p%0d_err_spurious", p), 64'(err_spurious[p]), 64'(e_sp[p]));
            check($sformatf("p%0d_err_timeout", p), 64'(err_timeout[p]), 64'(e_to[p]));
            if (e_cv[p]) begin
                check($sformatf("p%0d_cmp_tag", p), 64'(cmp_tag[p]), 64'(e_tag[p]));
                check($sformatf("p%0d_cmp_resp", p), 64'(cmp_resp[p]), 64'(e_resp[p]));
                check($sformatf("p%0d_cmp_data", p), 64'(cmp_data[p]), 64'(e_data[p]));
                check($sformatf("p%0d_cmp_cmd", p), 64'(cmp_cmd[p]), 64'(e_cmd[p]));
                check($sformatf("p%0d_cmp_lat", p), 64'(cmp_lat[p]), 64'(e_lat[p]));
            end
        end
    endtask

    task automatic model_edge();
        bit rdy;
        int at, rt;
        for (int p = 0; p < NP; p++) begin
            rdy = m_ready(p);
            at = -1;
            for (int t = NT - 1; t >= 0; t--) if (!m_busy[p][t]) at = t;
            e_cv[p] = 0; e_sp[p] = 0; e_to[p] = 0;
            if (duv_resp[p] != 2'b00) begin
                rt = int'(duv_rtag[p]);
                if (m_busy[p][rt]) begin
                    e_cv[p] = 1; e_tag[p] = rt; e_resp[p] = duv_resp[p];
                    e_data[p] = duv_rdata[p]; e_cmd[p] = m_tcmd[p][rt];
                    e_lat[p] = cyc - m_born[p][rt];
                    m_busy[p][rt] = 0;
                end else begin
                    e_sp[p] = 1;
                end
            end
            for (int t = 0; t < NT; t++) begin
                if (m_busy[p][t] && (cyc - m_born[p][t] == TO - 1)) begin
                    m_busy[p][t] = 0;
                    e_to[p] = 1;
                end
            end
            if (rdy && req_valid[p]) begin
                m_busy[p][at] = 1; m_born[p][at] = cyc + 1; m_tcmd[p][at] = req_cmd[p];
                m_acc[p] = cyc + 1; m_icmd[p] = req_cmd[p];
                m_op1[p] = req_op1[p]; m_op2[p] = req_op2[p]; m_itag[p] = at;
            end
        end
        cyc++;
    endtask

    task automatic run_cycle();
        @(negedge c_clk);
        check_outputs();
        model_edge();
        @(posedge c_clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int p = 0; p < NP; p++) begin
            req_valid[p] = 1'b0; req_cmd[p] = NOP; req_op1[p] = '0; req_op2[p] = '0;
            duv_resp[p] = 2'b00; duv_rtag[p] = '0; duv_rdata[p] = '0;
        end
    endtask

    task automatic issue(input int p, input operation_t c, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_valid[p] = 1'b1; req_cmd[p] = c; req_op1[p] = a; req_op2[p] = b;
    endtask

    initial begin
        int q [$];
        clear_inputs();
        model_reset();
        repeat (3) @(posedge c_clk);
        #1;
        check("rst_ready", 64'(req_ready), 64'(4'hf));
        check("rst_outstanding", 64'(outstanding[0]), 64'(0));
        check("rst_duv_cmd", 64'(duv_cmd[0]), 64'(NOP));
        reset = 1'b0;
        repeat (2) run_cycle();

        // Reset asserted while port 0 drives OP1
        issue(0, add_op, 32'h7, 32'h9);
        run_cycle();
        req_valid = '0;
        check("t1_op1_cmd", 64'(duv_cmd[0]), 64'(add_op));
        #2 reset = 1'b1;
        #1;
        check("t1_rst_cmd", 64'(duv_cmd[0]), 64'(NOP));
        check("t1_rst_outstanding", 64'(outstanding[0]), 64'(0));
        model_reset();
        @(posedge c_clk);
        #1 reset = 1'b0;
        check("t1_ready_after", 64'(req_ready[0]), 64'(1));
        run_cycle();

        // Single add on port 0, answered at age 6
        issue(0, add_op, 32'h5, 32'h3);
        run_cycle();
        req_valid = '0;
        check("t2_op1_cmd", 64'(duv_cmd[0]), 64'(add_op));
        check("t2_op1_data", 64'(duv_data[0]), 64'(5));
        check("t2_op1_tag", 64'(duv_tag[0]), 64'(0));
        run_cycle();
        check("t2_op2_cmd", 64'(duv_cmd[0]), 64'(NOP));
        check("t2_op2_data", 64'(duv_data[0]), 64'(3));
        repeat (5) run_cycle();
        duv_resp[0] = 2'b01; duv_rtag[0] = '0; duv_rdata[0] = 32'h8;
        run_cycle();
        clear_inputs();
        check("t2_cmp_valid", 64'(cmp_valid[0]), 64'(1));
        check("t2_cmp_data", 64'(cmp_data[0]), 64'(8));
        check("t2_cmp_cmd", 64'(cmp_cmd[0]), 64'(add_op));
        check("t2_cmp_lat", 64'(cmp_lat[0]), 64'(6));

        // Port 1 fills all tags, then one response frees tag 2 for reuse
        issue(1, sub_op, 32'h10, 32'h1);
        repeat (8) run_cycle();
        req_valid = '0;
        check("t3_ready_full", 64'(req_ready[1]), 64'(0));
        check("t3_outstanding", 64'(outstanding[1]), 64'(4));
        duv_resp[1] = 2'b01; duv_rtag[1] = 2'd2; duv_rdata[1] = 32'hf;
        run_cycle();
        clear_inputs();
        check("t3_ready_again", 64'(req_ready[1]), 64'(1));
        issue(1, shl_op, 32'h2, 32'h3);
        run_cycle();
        req_valid = '0;
        check("t3_reuse_tag", 64'(duv_tag[1]), 64'(2));

        // Spurious response on an idle port
        duv_resp[2] = 2'b01; duv_rtag[2] = 2'd3;
        run_cycle();
        clear_inputs();
        check("t4_spurious", 64'(err_spurious[2]), 64'(1));
        check("t4_no_cmp", 64'(cmp_valid[2]), 64'(0));
        check("t4_outstanding", 64'(outstanding[2]), 64'(0));

        // Unanswered request on port 3 times out
        issue(3, shr_op, 32'h40, 32'h2);
        run_cycle();
        req_valid = '0;
        repeat (15) run_cycle();
        check("t5_not_yet", 64'(err_timeout[3]), 64'(0));
        check("t5_still_busy", 64'(outstanding[3]), 64'(1));
        run_cycle();
        check("t5_timeout", 64'(err_timeout[3]), 64'(1));
        check("t5_freed", 64'(outstanding[3]), 64'(0));
        repeat (20) run_cycle();

        // All ports complete on the same edge
        for (int p = 0; p < NP; p++) issue(p, ops[p], 32'(p), 32'(p + 1));
        run_cycle();
        req_valid = '0;
        repeat (3) run_cycle();
        for (int p = 0; p < NP; p++) begin
            duv_resp[p] = 2'b01; duv_rtag[p] = '0; duv_rdata[p] = 32'h100 + 32'(p);
        end
        run_cycle();
        clear_inputs();
        check("t6_all_valid", 64'(cmp_valid), 64'(4'hf));
        for (int p = 0; p < NP; p++) begin
            check($sformatf("t6_p%0d_data", p), 64'(cmp_data[p]), 64'(32'h100 + 32'(p)));
            check($sformatf("t6_p%0d_cmd", p), 64'(cmp_cmd[p]), 64'(ops[p]));
        end

        // Randomized traffic against the model
        for (int k = 0; k < 1500; k++) begin
            for (int p = 0; p < NP; p++) begin
                req_valid[p] = ($urandom_range(0, 2) == 0);
                req_cmd[p] = ops[$urandom_range(0, 3)];
                req_op1[p] = $urandom;
                req_op2[p] = $urandom;
                duv_rtag[p] = 2'($urandom_range(0, NT - 1));
                duv_rdata[p] = $urandom;
                duv_resp[p] = 2'b00;
                if ($urandom_range(0, 3) == 0) begin
                    duv_resp[p] = 2'($urandom_range(1, 3));
                    q.delete();
                    for (int t = 0; t < NT; t++) if (m_busy[p][t]) q.push_back(t);
                    if (q.size() > 0 && $urandom_range(0, 4) != 0)
                        duv_rtag[p] = 2'(q[$urandom_range(0, q.size() - 1)]);
                end
            end
            run_cycle();
        end
        clear_inputs();
        repeat (2) run_cycle();

        reset = 1'b1;
        #1;
        check("end_rst_outstanding", 64'(outstanding[1]), 64'(0));
        check("end_rst_cmp", 64'(cmp_valid), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
